// File: rtl/top_pkg.sv
// top_pkg: colour codes, ASCII display values and FSM state encoding
// shared by the colour-indicator unit.
package top_pkg;

    localparam logic [2:0] COL_NONE    = 3'b000;
    localparam logic [2:0] COL_RED     = 3'b001;
    localparam logic [2:0] COL_GREEN   = 3'b010;
    localparam logic [2:0] COL_BLUE    = 3'b011;
    localparam logic [2:0] COL_YELLOW  = 3'b100;
    localparam logic [2:0] COL_WHITE   = 3'b101;
    localparam logic [2:0] COL_BLACK   = 3'b110;
    localparam logic [2:0] COL_INVALID = 3'b111;

    localparam logic [7:0] ASC_NONE    = 8'h20;
    localparam logic [7:0] ASC_RED     = 8'h52;
    localparam logic [7:0] ASC_GREEN   = 8'h47;
    localparam logic [7:0] ASC_BLUE    = 8'h42;
    localparam logic [7:0] ASC_YELLOW  = 8'h59;
    localparam logic [7:0] ASC_WHITE   = 8'h57;
    localparam logic [7:0] ASC_BLACK   = 8'h4B;
    localparam logic [7:0] ASC_INVALID = 8'h3F;

    // Indexed directly by the 3-bit colour code.
    localparam logic [7:0] ASCII_LUT [8] = '{
        ASC_NONE, ASC_RED, ASC_GREEN, ASC_BLUE,
        ASC_YELLOW, ASC_WHITE, ASC_BLACK, ASC_INVALID
    };

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_BEEP   = 2'd2
    } state_t;

    function automatic logic [7:0] ascii_of(input logic [2:0] c);
        return ASCII_LUT[c];
    endfunction

endpackage

// File: rtl/top_tone_gen.sv
// tone_gen: square wave toggling every HALF_PERIOD enabled cycles;
// counter and output clear to 0 whenever en is low.
module tone_gen #(
    parameter int HALF_PERIOD = 12_500
) (
    input  logic clk,
    input  logic Reset,
    input  logic en,
    output logic o_wave
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    logic [CW-1:0] r_cnt  = '0;
    logic          r_wave = 1'b0;
    logic          w_wrap;

    assign w_wrap = r_cnt == CW'(HALF_PERIOD - 1);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (!en) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
            r_wave <= r_wave ^ w_wrap;
        end
    end

    assign o_wave = r_wave;

endmodule

// File: rtl/top.sv
// top: colour-indicator unit; debounces a ready-qualified colour code,
// shows the accepted colour as ASCII and beeps on every change.
module top
    import top_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TONE_HZ     = 2_000,
    parameter int BEEP_CYCLES = 5_000_000,
    parameter int STABLE_N    = 16
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       ready_i,
    input  logic [2:0] Color,
    output logic [7:0] Data,
    output logic       Buzzer
);

    localparam int HALF_PERIOD = CLK_HZ / (2 * TONE_HZ);
    localparam int SW = $clog2(STABLE_N + 1);
    localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

    state_t        r_state = S_IDLE;
    state_t        w_next;
    logic [2:0]    r_cand  = COL_NONE;
    logic [2:0]    r_acc   = COL_NONE;
    logic [SW-1:0] r_stab  = '0;
    logic [BW-1:0] r_beep  = '0;
    logic [7:0]    r_data  = ASC_NONE;
    logic          w_stable;
    logic          w_beep_done;
    logic          w_tone_en;
    logic          w_wave;

    assign w_stable    = r_stab == SW'(STABLE_N);
    assign w_beep_done = r_beep == BW'(BEEP_CYCLES - 1);
    // Dropping en in the last beep cycle leaves the buzzer at 0 on exit.
    assign w_tone_en   = (r_state == S_BEEP) && !w_beep_done;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_cand <= COL_NONE;
            r_stab <= '0;
        end else if (ready_i) begin
            if (Color == r_cand) begin
                r_stab <= w_stable ? r_stab : r_stab + 1'b1;
            end else begin
                r_cand <= Color;
                r_stab <= SW'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = (w_stable && r_cand != r_acc) ? S_UPDATE : S_IDLE;
            S_UPDATE: w_next = (r_cand != COL_NONE) ? S_BEEP : S_IDLE;
            S_BEEP:   w_next = w_beep_done ? S_IDLE : S_BEEP;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_acc   <= COL_NONE;
            r_data  <= ASC_NONE;
            r_beep  <= '0;
        end else begin
            r_state <= w_next;
            r_beep  <= w_tone_en ? r_beep + 1'b1 : '0;
            if (r_state == S_UPDATE) begin
                r_acc  <= r_cand;
                r_data <= ascii_of(r_cand);
            end
        end
    end

    tone_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_tone (
        .clk   (clk),
        .Reset (Reset),
        .en    (w_tone_en),
        .o_wave(w_wave)
    );

    assign Data   = r_data;
    assign Buzzer = w_wave;

endmodule

// File: tb/tb_top.sv
// tb_top: directed checks of the colour-indicator unit, a small-parameter
// instance for sequencing plus a default-parameter instance never reset.
module tb_top;

    logic       clk = 1'b0;
    logic       Reset, ready_i;
    logic [2:0] Color;
    logic [7:0] Data;
    logic       Buzzer;
    logic       rst2, rdy2;
    logic [2:0] col2;
    logic [7:0] d2;
    logic       b2;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    top #(
        .CLK_HZ(100), .TONE_HZ(10), .BEEP_CYCLES(40), .STABLE_N(4)
    ) dut (
        .clk(clk), .Reset(Reset), .ready_i(ready_i), .Color(Color),
        .Data(Data), .Buzzer(Buzzer)
    );

    top dut_dflt (
        .clk(clk), .Reset(rst2), .ready_i(rdy2), .Color(col2),
        .Data(d2), .Buzzer(b2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        Reset = 1'b1; ready_i = 1'b0; Color = 3'b000;
        rst2 = 1'b0; rdy2 = 1'b1; col2 = 3'b010;
        // default instance: first sample at edge 1, visible after edge 18
        wait_cyc(17);
        chk("dflt_data_pre", d2, 8'h20);
        chk("rst_data", Data, 8'h20);
        chk("rst_buzz", {7'd0, Buzzer}, 8'h00);
        wait_cyc(18);
        chk("dflt_data", d2, 8'h47);
        Reset = 1'b0;
        step(1);
        // red held: Data at 6th edge, 40-cycle beep toggling every 5
        Color = 3'b001; ready_i = 1'b1;
        step(5);  chk("t1_lat5", Data, 8'h20);
        step(1);  chk("t1_lat6", Data, 8'h52);
        step(4);  chk("t1_bz10", {7'd0, Buzzer}, 8'h00);
        step(1);  chk("t1_bz11", {7'd0, Buzzer}, 8'h01);
        step(4);  chk("t1_bz15", {7'd0, Buzzer}, 8'h01);
        step(1);  chk("t1_bz16", {7'd0, Buzzer}, 8'h00);
        step(25); chk("t1_bz41", {7'd0, Buzzer}, 8'h01);
        step(4);  chk("t1_bz45", {7'd0, Buzzer}, 8'h01);
        step(1);  chk("t1_bz46", {7'd0, Buzzer}, 8'h00);
        step(14); chk("t1_bz60", {7'd0, Buzzer}, 8'h00);
        chk("t1_hold", Data, 8'h52);
        // alternating codes never settle
        Reset = 1'b1; step(1); Reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            Color = i[0] ? 3'b010 : 3'b001;
            step(1);
        end
        chk("t3_data", Data, 8'h20);
        chk("t3_buzz", {7'd0, Buzzer}, 8'h00);
        // blue with ready toggling: counts samples, not clocks
        Color = 3'b011;
        for (int i = 0; i < 4; i++) begin
            ready_i = 1'b1; step(1);
            ready_i = 1'b0; step(1);
            if (i == 1) chk("t4_4clk", Data, 8'h20);
        end
        chk("t4_pre", Data, 8'h20);
        step(1);  chk("t4_data", Data, 8'h42);
        step(5);  chk("t4_bz", {7'd0, Buzzer}, 8'h01);
        step(40);
        // red then yellow mid-beep: first beep completes, second follows
        Color = 3'b001; ready_i = 1'b1;
        step(6);  chk("t5_red", Data, 8'h52);
        step(4);  Color = 3'b100;
        step(35); chk("t5_bz45", {7'd0, Buzzer}, 8'h01);
        step(1);  chk("t5_bz46", {7'd0, Buzzer}, 8'h00);
        chk("t5_d46", Data, 8'h52);
        step(1);  chk("t5_d47", Data, 8'h52);
        step(1);  chk("t5_d48", Data, 8'h59);
        step(5);  chk("t5_bz53", {7'd0, Buzzer}, 8'h01);
        step(34); chk("t5_bz87", {7'd0, Buzzer}, 8'h01);
        step(1);  chk("t5_bz88", {7'd0, Buzzer}, 8'h00);
        step(7);  chk("t5_nobeep", {7'd0, Buzzer}, 8'h00);
        chk("t5_hold", Data, 8'h59);
        // async reset mid-beep, then silent acceptance of code 000
        Color = 3'b101;
        step(11); chk("t6_bz", {7'd0, Buzzer}, 8'h01);
        chk("t6_data", Data, 8'h57);
        Reset = 1'b1;
        #1;
        chk("t6_rst_bz", {7'd0, Buzzer}, 8'h00);
        chk("t6_rst_d", Data, 8'h20);
        Color = 3'b000;
        @(negedge clk);
        Reset = 1'b0;
        step(11); chk("t6_none_bz", {7'd0, Buzzer}, 8'h00);
        chk("t6_none_d", Data, 8'h20);
        // default instance tone: half-period 12_500, beep entered at edge 18
        wait_cyc(12517); chk("dflt_bz_a", {7'd0, b2}, 8'h00);
        wait_cyc(12518); chk("dflt_bz_b", {7'd0, b2}, 8'h01);
        wait_cyc(25017); chk("dflt_bz_c", {7'd0, b2}, 8'h01);
        wait_cyc(25018); chk("dflt_bz_d", {7'd0, b2}, 8'h00);
        wait_cyc(37518); chk("dflt_bz_e", {7'd0, b2}, 8'h01);
        wait_cyc(50018); chk("dflt_bz_f", {7'd0, b2}, 8'h00);
        chk("dflt_data_end", d2, 8'h47);
        chk("dflt_nox", {7'd0, $isunknown({d2, b2})}, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
